rocketcpu_adsr_envelope: RTL and testbench

//  ADSR envelope generator sitting directly downstream of the CPU audio

---
 rtl/rocketcpu_adsr_envelope.sv | 132 +++++++++++++
 tb/tb_rocketcpu_adsr_envelope.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rocketcpu_adsr_envelope.sv
// ADSR envelope generator, stepped once per audio sample strobe.
// Ports: i_clk, i_rst_n (async low), i_sample_stb, i_gate, rates and
// sustain level in; o_env level, o_env_valid, o_state, o_active out.
module rocketcpu_adsr_envelope #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sample_stb,
  input  logic             i_gate,
  input  logic [ACC_W-1:0] i_attack_inc,
  input  logic [ACC_W-1:0] i_decay_dec,
  input  logic [WIDTH-1:0] i_sustain_lvl,
  input  logic [ACC_W-1:0] i_release_dec,
  output logic [WIDTH-1:0] o_env,
  output logic             o_env_valid,
  output logic [2:0]       o_state,
  output logic             o_active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [ACC_W-1:0] MAX = '1;

  state_t           state;
  state_t           state_n;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_n;
  logic             gate_q;
  logic             valid_q;

  logic [ACC_W-1:0] sus;
  logic [ACC_W:0]   att_sum;
  logic [ACC_W:0]   dec_dif;
  logic [ACC_W:0]   rel_dif;
  logic             rise;
  logic             fall;
  logic             held;

  // sustain level occupies the top WIDTH bits of the accumulator
  assign sus = ACC_W'(i_sustain_lvl) << (ACC_W - WIDTH);

  // one extra bit so overflow/borrow is visible instead of wrapping
  assign att_sum = {1'b0, acc} + {1'b0, i_attack_inc};
  assign dec_dif = {1'b0, acc} - {1'b0, i_decay_dec};
  assign rel_dif = {1'b0, acc} - {1'b0, i_release_dec};

  assign rise = i_gate & ~gate_q;
  assign fall = ~i_gate & gate_q;
  assign held = (state == ATTACK) | (state == DECAY)
              | (state == SUSTAIN);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    if (rise) begin
      state_n = ATTACK;
    end else if (fall && held) begin
      state_n = RELEASE;
    end else begin
      case (state)
        IDLE: begin
          acc_n = '0;
        end
        ATTACK: begin
          if (i_attack_inc == '0 ||
              att_sum >= {1'b0, MAX}) begin
            acc_n   = MAX;
            state_n = DECAY;
          end else begin
            acc_n = att_sum[ACC_W-1:0];
          end
        end
        DECAY: begin
          // a borrow means acc - dec went below zero, hence below SUS
          if (i_decay_dec == '0 || dec_dif[ACC_W] ||
              dec_dif[ACC_W-1:0] <= sus) begin
            acc_n   = sus;
            state_n = SUSTAIN;
          end else begin
            acc_n = dec_dif[ACC_W-1:0];
          end
        end
        SUSTAIN: begin
          acc_n = sus;
        end
        RELEASE: begin
          if (i_release_dec == '0 || rel_dif[ACC_W] ||
              rel_dif[ACC_W-1:0] == '0) begin
            acc_n   = '0;
            state_n = IDLE;
          end else begin
            acc_n = rel_dif[ACC_W-1:0];
          end
        end
        default: begin
          acc_n   = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      gate_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= i_sample_stb;
      if (i_sample_stb) begin
        state  <= state_n;
        acc    <= acc_n;
        gate_q <= i_gate;
      end
    end
  end

  assign o_env       = acc[ACC_W-1 -: WIDTH];
  assign o_env_valid = valid_q;
  assign o_state     = state;
  assign o_active    = (state != IDLE);

endmodule

// File: tb/tb_rocketcpu_adsr_envelope.sv
// Self-checking bench for rocketcpu_adsr_envelope.
// Directed note sequence with literal pins, then random stimulus.
module tb_rocketcpu_adsr_envelope;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        gate = 1'b0;
  logic [31:0] ainc = '0;
  logic [31:0] ddec = '0;
  logic [15:0] slvl = '0;
  logic [31:0] rdec = '0;
  logic [15:0] env;
  logic        env_valid;
  logic [2:0]  st;
  logic        active;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rocketcpu_adsr_envelope #(.WIDTH(16), .ACC_W(32)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sample_stb  (stb),
    .i_gate        (gate),
    .i_attack_inc  (ainc),
    .i_decay_dec   (ddec),
    .i_sustain_lvl (slvl),
    .i_release_dec (rdec),
    .o_env         (env),
    .o_env_valid   (env_valid),
    .o_state       (st),
    .o_active      (active)
  );

  // reference model: level as a plain 64-bit number, phase as 0..4
  longint unsigned m_acc = 0;
  int              m_st = 0;
  bit              m_gq = 1'b0;
  bit              m_vld = 1'b0;

  localparam longint unsigned TOP = 64'hFFFF_FFFF;

  function automatic void mstep(
    input  longint unsigned a,
    input  int              s,
    input  bit              gq,
    input  bit              g,
    output longint unsigned na,
    output int              ns
  );
    longint unsigned su;
    longint unsigned ai;
    longint unsigned di;
    longint unsigned ri;
    su = longint'(slvl) * 65536;
    ai = longint'(ainc);
    di = longint'(ddec);
    ri = longint'(rdec);
    na = a;
    ns = s;
    if (g && !gq) begin
      ns = 1;
    end else if (!g && gq && s >= 1 && s <= 3) begin
      ns = 4;
    end else if (s == 1) begin
      if (ai == 0 || a + ai >= TOP) begin
        na = TOP;
        ns = 2;
      end else begin
        na = a + ai;
      end
    end else if (s == 2) begin
      if (di == 0 || a <= su + di) begin
        na = su;
        ns = 3;
      end else begin
        na = a - di;
      end
    end else if (s == 3) begin
      na = su;
    end else if (s == 4) begin
      if (ri == 0 || a <= ri) begin
        na = 0;
        ns = 0;
      end else begin
        na = a - ri;
      end
    end else begin
      na = 0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    longint unsigned na;
    int              ns;
    if (!rst_n) begin
      m_acc <= 0;
      m_st  <= 0;
      m_gq  <= 1'b0;
      m_vld <= 1'b0;
    end else begin
      m_vld <= stb;
      if (stb) begin
        mstep(m_acc, m_st, m_gq, gate, na, ns);
        m_acc <= na;
        m_st  <= ns;
        m_gq  <= gate;
      end
    end
  end

  // every-cycle compare against the model
  always @(negedge clk) begin
    logic [15:0] e_env;
    if (chk_en) begin
      e_env = m_acc[31:16];
      checks++;
      if (env !== e_env) begin
        errors++;
        $display("FAIL env t=%0t got %h want %h",
                 $time, env, e_env);
      end
      checks++;
      if (st !== 3'(m_st)) begin
        errors++;
        $display("FAIL state t=%0t got %0d want %0d",
                 $time, st, m_st);
      end
      checks++;
      if (active !== (m_st != 0)) begin
        errors++;
        $display("FAIL active t=%0t got %b want %b",
                 $time, active, m_st != 0);
      end
      checks++;
      if (env_valid !== m_vld) begin
        errors++;
        $display("FAIL valid t=%0t got %b want %b",
                 $time, env_valid, m_vld);
      end
    end
  end

  task automatic pin(input string nm,
                     input logic [15:0] e,
                     input logic [2:0] s);
    checks++;
    if (env !== e || st !== s || active !== (s != 0)) begin
      errors++;
      $display("FAIL %s got env=%h st=%0d act=%b want env=%h st=%0d",
               nm, env, st, active, e, s);
    end
  endtask

  task automatic pin_vld(input string nm, input logic v);
    checks++;
    if (env_valid !== v) begin
      errors++;
      $display("FAIL %s got valid=%b want %b", nm, env_valid, v);
    end
  endtask

  // one strobe; returns 1ns after the following negedge
  task automatic strobe();
    @(negedge clk);
    #1 stb = 1'b1;
    @(negedge clk);
    #1 stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_rate();
    logic [31:0] r;
    case ($urandom_range(0, 4))
      0: r = '0;
      1: r = $urandom;
      2: r = $urandom >> 3;
      default: r = $urandom >> $urandom_range(6, 26);
    endcase
    return r;
  endfunction

  initial begin
    logic [15:0] hold_env;
    logic [2:0]  hold_st;

    // reset with gate already high
    gate = 1'b1;
    ainc = 32'h1000_0000;
    ddec = 32'h1000_0000;
    slvl = 16'h8000;
    rdec = 32'h2000_0000;
    idle(3);
    chk_en = 1'b1;
    idle(1);
    pin("reset", 16'h0000, 3'd0);
    pin_vld("reset_valid", 1'b0);
    rst_n = 1'b1;
    idle(2);
    strobe();
    pin("rise_after_reset", 16'h0000, 3'd1);
    pin_vld("valid_after_stb", 1'b1);
    idle(1);
    pin_vld("valid_one_clk", 1'b0);

    // attack: 15 steps then clamp
    repeat (15) strobe();
    pin("attack_15", 16'hF000, 3'd1);
    strobe();
    pin("attack_max", 16'hFFFF, 3'd2);

    // decay to sustain, then live sustain change
    repeat (7) strobe();
    pin("decay_7", 16'h8FFF, 3'd2);
    strobe();
    pin("decay_clamp", 16'h8000, 3'd3);
    slvl = 16'h4000;
    strobe();
    pin("sustain_track", 16'h4000, 3'd3);

    // release and retrigger mid-release
    gate = 1'b0;
    strobe();
    pin("release_enter", 16'h4000, 3'd4);
    strobe();
    pin("release_step", 16'h2000, 3'd4);
    gate = 1'b1;
    ainc = '0;
    strobe();
    pin("retrigger", 16'h2000, 3'd1);
    strobe();
    pin("instant_attack", 16'hFFFF, 3'd2);

    // full release down to idle (exact landing on 0 below)
    gate = 1'b0;
    strobe();
    pin("release2_enter", 16'hFFFF, 3'd4);
    repeat (8) strobe();
    pin("release2_idle", 16'h0000, 3'd0);

    // exact-zero release path: 0x4000_0000 / 0x2000_0000
    gate = 1'b1;
    slvl = 16'h4000;
    ddec = '0;
    repeat (3) strobe();
    pin("instant_decay", 16'h4000, 3'd3);
    gate = 1'b0;
    strobe();
    strobe();
    pin("rel_half", 16'h2000, 3'd4);
    strobe();
    pin("rel_zero", 16'h0000, 3'd0);

    // gate toggling with no strobe is invisible
    gate = 1'b1;
    strobe();
    strobe();
    hold_env = env;
    hold_st  = st;
    for (int i = 0; i < 100; i++) begin
      gate = ~gate;
      idle(1);
    end
    pin("no_strobe", hold_env, hold_st);

    // reset mid-note
    rst_n = 1'b0;
    idle(2);
    pin("mid_reset", 16'h0000, 3'd0);
    rst_n = 1'b1;
    idle(1);
    strobe();
    pin("mid_reset_rise", 16'h0000, 3'd1);

    // randomized stimulus
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      stb = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) gate = ~gate;
      if ($urandom_range(0, 29) == 0) ainc = rnd_rate();
      if ($urandom_range(0, 29) == 0) ddec = rnd_rate();
      if ($urandom_range(0, 29) == 0) rdec = rnd_rate();
      if ($urandom_range(0, 29) == 0) slvl = 16'($urandom);
      if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    stb = 1'b0;
    rst_n = 1'b1;
    idle(3);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
